// File: rtl/rv16_sub_seq.sv
`default_nettype none
// ============================================================================
// rv16_sub_seq : multi-word subtract sequencer, one DATA-bit word per cycle
//                through an external subtract unit, LSW first, borrow chained.
// Optional: SUB_SEQ_FLAGS_EN adds zero/neg/ovf result flags.
// Rev 1.0
// ============================================================================
module rv16_sub_seq #(
  parameter int DATA  = 16,
  parameter int WORDS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA*WORDS-1:0] rs1_in,
  input  logic [DATA*WORDS-1:0] rs2_in,
  input  logic                  bin_in,
  input  logic [3:0]            tag_in,
  output logic [DATA-1:0]       sub_a,
  output logic [DATA-1:0]       sub_b,
  output logic                  sub_bin,
  input  logic [DATA-1:0]       sub_diff,
  input  logic                  sub_bout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA*WORDS-1:0] rd_out,
  output logic                  bout,
  output logic [3:0]            tag_out
`ifdef SUB_SEQ_FLAGS_EN
  ,
  output logic                  zero_out,
  output logic                  neg_out,
  output logic                  ovf_out
`endif
);

  localparam int W    = DATA * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_rs1;
  logic [W-1:0]    r_rs2;
  logic            r_borrow;
  logic [IDXW-1:0] r_idx;
  logic [IDXW-1:0] w_sel;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);

  // Outside RUN the subtract unit sees latched word 0 and a zero borrow.
  assign w_sel   = (r_state == S_RUN) ? r_idx : '0;
  assign sub_a   = r_rs1[w_sel*DATA +: DATA];
  assign sub_b   = r_rs2[w_sel*DATA +: DATA];
  assign sub_bin = (r_state == S_RUN) ? r_borrow : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_borrow <= 1'b0;
      r_idx    <= '0;
      rd_out   <= '0;
      bout     <= 1'b0;
      tag_out  <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_rs1    <= rs1_in;
            r_rs2    <= rs2_in;
            r_borrow <= bin_in;
            tag_out  <= tag_in;
            r_idx    <= '0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          rd_out[r_idx*DATA +: DATA] <= sub_diff;
          r_borrow <= sub_bout;
          if (r_idx == C_LAST_IDX) begin
            bout    <= sub_bout;
            r_idx   <= '0;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SUB_SEQ_FLAGS_EN
  // Flags qualified by out_valid so they read 0 out of reset and while busy.
  assign zero_out = out_valid & (rd_out == '0);
  assign neg_out  = out_valid & rd_out[W-1];
  assign ovf_out  = out_valid & (r_rs1[W-1] != r_rs2[W-1]) & (rd_out[W-1] != r_rs1[W-1]);
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv16_sub_seq.sv
`default_nettype none
// ============================================================================
// tb_rv16_sub_seq : randomized bench for rv16_sub_seq (WORDS=2 and WORDS=1)
// Rev 1.0
// ============================================================================
module tb_rv16_sub_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- WORDS=2 instance ----------------
  logic        in_valid, in_ready, bin_in, out_valid, out_ready, bout, sub_bin, sub_bout;
  logic [31:0] rs1_in, rs2_in, rd_out;
  logic [3:0]  tag_in, tag_out;
  logic [15:0] sub_a, sub_b, sub_diff;
`ifdef SUB_SEQ_FLAGS_EN
  logic zero_out, neg_out, ovf_out;
`endif

  assign {sub_bout, sub_diff} = {1'b0, sub_a} - {1'b0, sub_b} - {16'd0, sub_bin};

  rv16_sub_seq #(.DATA(16), .WORDS(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_in(rs1_in), .rs2_in(rs2_in), .bin_in(bin_in), .tag_in(tag_in),
    .sub_a(sub_a), .sub_b(sub_b), .sub_bin(sub_bin), .sub_diff(sub_diff), .sub_bout(sub_bout),
    .out_valid(out_valid), .out_ready(out_ready), .rd_out(rd_out), .bout(bout), .tag_out(tag_out)
`ifdef SUB_SEQ_FLAGS_EN
    , .zero_out(zero_out), .neg_out(neg_out), .ovf_out(ovf_out)
`endif
  );

  // ---------------- WORDS=1 instance ----------------
  logic        in_valid1, in_ready1, bin_in1, out_valid1, out_ready1, bout1, sub_bin1, sub_bout1;
  logic [15:0] rs1_in1, rs2_in1, rd_out1, sub_a1, sub_b1, sub_diff1;
  logic [3:0]  tag_in1, tag_out1;
`ifdef SUB_SEQ_FLAGS_EN
  logic zero_out1, neg_out1, ovf_out1;
`endif

  assign {sub_bout1, sub_diff1} = {1'b0, sub_a1} - {1'b0, sub_b1} - {16'd0, sub_bin1};

  rv16_sub_seq #(.DATA(16), .WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .rs1_in(rs1_in1), .rs2_in(rs2_in1), .bin_in(bin_in1), .tag_in(tag_in1),
    .sub_a(sub_a1), .sub_b(sub_b1), .sub_bin(sub_bin1), .sub_diff(sub_diff1), .sub_bout(sub_bout1),
    .out_valid(out_valid1), .out_ready(out_ready1), .rd_out(rd_out1), .bout(bout1), .tag_out(tag_out1)
`ifdef SUB_SEQ_FLAGS_EN
    , .zero_out(zero_out1), .neg_out(neg_out1), .ovf_out(ovf_out1)
`endif
  );

  // Reference: full-precision subtract, borrow = result went negative.
  task automatic run2(input logic [31:0] a, input logic [31:0] b, input logic bi,
                      input logic [3:0] t, input int hold, input bit poke);
    logic [63:0] full;
    logic [31:0] exp_rd;
    logic        exp_bo, exp_w1bin, w1bin;
    longint      sdiff;
    int          cyc;
    full      = {32'd0, a} - {32'd0, b} - {63'd0, bi};
    exp_rd    = full[31:0];
    exp_bo    = full[63];
    exp_w1bin = ({1'b0, a[15:0]} < ({1'b0, b[15:0]} + {16'd0, bi}));
    sdiff     = longint'($signed(a)) - longint'($signed(b)) - longint'(bi);
    out_ready = (hold == 0);
    cyc = 0;
    while (!in_ready && cyc < 50) begin @(posedge clk); #1; cyc++; end
    check("in_ready_idle", {63'd0, in_ready}, 64'd1);
    rs1_in = a; rs2_in = b; bin_in = bi; tag_in = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; rs1_in = $urandom; rs2_in = $urandom; bin_in = ~bi; tag_in = ~t;
    check("run_w0_bin", {63'd0, sub_bin}, {63'd0, bi});
    cyc = 0; w1bin = 1'b0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1; cyc++;
      if (cyc == 1) w1bin = sub_bin;
    end
    check("latency", 64'(cyc), 64'd2);
    check("w1_bin", {63'd0, w1bin}, {63'd0, exp_w1bin});
    check("rd_out", {32'd0, rd_out}, {32'd0, exp_rd});
    check("bout", {63'd0, bout}, {63'd0, exp_bo});
    check("tag_out", {60'd0, tag_out}, {60'd0, t});
    check("busy_in_ready", {63'd0, in_ready}, 64'd0);
`ifdef SUB_SEQ_FLAGS_EN
    check("zero", {63'd0, zero_out}, {63'd0, (exp_rd == 32'd0)});
    check("neg", {63'd0, neg_out}, {63'd0, exp_rd[31]});
    check("ovf", {63'd0, ovf_out}, {63'd0, (sdiff > 64'sd2147483647) || (sdiff < -64'sd2147483648)});
`endif
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        in_valid = 1'b1; rs1_in = $urandom; rs2_in = $urandom; tag_in = 4'($urandom);
      end
      @(posedge clk); #1;
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_rd", {32'd0, rd_out}, {32'd0, exp_rd});
      check("hold_bout_tag", {59'd0, bout, tag_out}, {59'd0, exp_bo, t});
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("xfer_out_valid", {63'd0, out_valid}, 64'd0);
    check("xfer_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic run1(input logic [15:0] a, input logic [15:0] b, input logic bi, input logic [3:0] t);
    logic [31:0] full;
    int          cyc;
    full = {16'd0, a} - {16'd0, b} - {31'd0, bi};
    out_ready1 = 1'b1;
    rs1_in1 = a; rs2_in1 = b; bin_in1 = bi; tag_in1 = t; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    cyc = 0;
    while (!out_valid1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check("w1_latency", 64'(cyc), 64'd1);
    check("w1_rd", {48'd0, rd_out1}, {48'd0, full[15:0]});
    check("w1_bout", {63'd0, bout1}, {63'd0, full[31]});
    check("w1_tag", {60'd0, tag_out1}, {60'd0, t});
    @(posedge clk); #1;
    check("w1_idle", {62'd0, in_ready1, out_valid1}, 64'd2);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; rs1_in = '0; rs2_in = '0; bin_in = 1'b0; tag_in = '0; out_ready = 1'b1;
    in_valid1 = 1'b0; rs1_in1 = '0; rs2_in1 = '0; bin_in1 = 1'b0; tag_in1 = '0; out_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_valid", {62'd0, in_ready, out_valid}, 64'd2);
    check("rst_rd_bout_tag", {27'd0, rd_out, bout, tag_out}, 64'd0);
    check("rst_sub", {31'd0, sub_a, sub_b, sub_bin}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run2(32'h0001_0000, 32'h0000_0001, 1'b0, 4'h5, 0, 1'b0);
    run2(32'h0000_0000, 32'h0000_0001, 1'b0, 4'h6, 0, 1'b0);
    run2(32'h8000_0000, 32'h0000_0001, 1'b0, 4'h7, 0, 1'b0);
    run2(32'h1234_5678, 32'h1234_5678, 1'b1, 4'h8, 0, 1'b0);
    // Back-pressure with ignored requests, then a normal follow-up.
    run2(32'hDEAD_BEEF, 32'h1111_2222, 1'b0, 4'h9, 5, 1'b1);
    run2(32'h0000_0003, 32'h0000_0002, 1'b1, 4'hA, 0, 1'b0);

    // Reset in RUN after word 0 has been processed.
    rs1_in = 32'hAAAA_5555; rs2_in = 32'h1234_0001; bin_in = 1'b1; tag_in = 4'hC; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready_valid", {62'd0, in_ready, out_valid}, 64'd2);
    check("abort_rd_bout_tag", {27'd0, rd_out, bout, tag_out}, 64'd0);
    check("abort_sub", {31'd0, sub_a, sub_b, sub_bin}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_no_valid", {63'd0, out_valid}, 64'd0);
    end
    run2(32'h0000_0010, 32'h0000_0020, 1'b0, 4'hD, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      if (n % 8 == 0) b = a;
      if (n % 8 == 1) a[15:0] = b[15:0];
      run2(a, b, 1'($urandom), 4'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    run1(16'h0005, 16'h0007, 1'b0, 4'd3);
    for (int n = 0; n < 10; n++) run1(16'($urandom), 16'($urandom), 1'($urandom), 4'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
